// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: opcodes, IR field positions, sequencer states, ALU strobe indices.
package cpu_ctrl_pkg;

  localparam int unsigned OpW     = 5;
  localparam int unsigned RegW    = 4;
  localparam int unsigned NumRegs = 16;
  localparam int unsigned AluW    = 13;
  localparam int unsigned IrW     = 32;

  // IR field positions (LSB of each field)
  localparam int unsigned IrOpLsb = 27;
  localparam int unsigned IrRaLsb = 23;
  localparam int unsigned IrRbLsb = 19;
  localparam int unsigned IrRcLsb = 15;

  typedef logic [OpW-1:0] opcode_t;

  localparam opcode_t OpAdd  = 5'b00011;
  localparam opcode_t OpSub  = 5'b00100;
  localparam opcode_t OpShr  = 5'b00101;
  localparam opcode_t OpShra = 5'b00110;
  localparam opcode_t OpShl  = 5'b00111;
  localparam opcode_t OpRor  = 5'b01000;
  localparam opcode_t OpRol  = 5'b01001;
  localparam opcode_t OpAnd  = 5'b01010;
  localparam opcode_t OpOr   = 5'b01011;
  localparam opcode_t OpMul  = 5'b01111;
  localparam opcode_t OpDiv  = 5'b10000;
  localparam opcode_t OpNeg  = 5'b10001;
  localparam opcode_t OpNot  = 5'b10010;
  localparam opcode_t OpHalt = 5'b11011;

  // alu_op is {ADD,SUB,MUL,DIV,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}, ADD in the MSB
  localparam int unsigned AluAdd  = 12;
  localparam int unsigned AluSub  = 11;
  localparam int unsigned AluMul  = 10;
  localparam int unsigned AluDiv  = 9;
  localparam int unsigned AluAnd  = 8;
  localparam int unsigned AluOr   = 7;
  localparam int unsigned AluShr  = 6;
  localparam int unsigned AluShra = 5;
  localparam int unsigned AluShl  = 4;
  localparam int unsigned AluRor  = 3;
  localparam int unsigned AluRol  = 2;
  localparam int unsigned AluNeg  = 1;
  localparam int unsigned AluNot  = 0;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsTwoOp,
    ClsMulDiv,
    ClsUnary,
    ClsHalt,
    ClsIllegal
  } op_class_e;

  function automatic op_class_e op_class(opcode_t op);
    op_class_e cls;
    case (op)
      OpAdd, OpSub, OpShr, OpShra, OpShl,
      OpRor, OpRol, OpAnd, OpOr:           cls = ClsTwoOp;
      OpMul, OpDiv:                        cls = ClsMulDiv;
      OpNeg, OpNot:                        cls = ClsUnary;
      OpHalt:                              cls = ClsHalt;
      default:                             cls = ClsIllegal;
    endcase
    return cls;
  endfunction

  function automatic logic [AluW-1:0] alu_onehot(opcode_t op);
    logic [AluW-1:0] v;
    v = '0;
    case (op)
      OpAdd:   v[AluAdd]  = 1'b1;
      OpSub:   v[AluSub]  = 1'b1;
      OpMul:   v[AluMul]  = 1'b1;
      OpDiv:   v[AluDiv]  = 1'b1;
      OpAnd:   v[AluAnd]  = 1'b1;
      OpOr:    v[AluOr]   = 1'b1;
      OpShr:   v[AluShr]  = 1'b1;
      OpShra:  v[AluShra] = 1'b1;
      OpShl:   v[AluShl]  = 1'b1;
      OpRor:   v[AluRor]  = 1'b1;
      OpRol:   v[AluRol]  = 1'b1;
      OpNeg:   v[AluNeg]  = 1'b1;
      OpNot:   v[AluNot]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/reg_field_decode.sv
// Register index to one-hot select, all zeros when disabled.
module reg_field_decode #(
  parameter int unsigned IdxW  = 4,
  parameter int unsigned Width = 1 << IdxW
) (
  input  logic             i_en,
  input  logic [IdxW-1:0]  i_idx,
  output logic [Width-1:0] o_onehot
);

  // Single bit set at the selected index when enabled
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer for register-register ALU instructions.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic                 i_clock,
  input  logic                 i_clear,
  input  logic                 i_run,
  input  logic [IrW-1:0]       i_ir,
  output logic [NumRegs-1:0]   o_r_in,
  output logic [NumRegs-1:0]   o_r_out,
  output logic                 o_pc_in,
  output logic                 o_pc_out,
  output logic                 o_inc_pc,
  output logic                 o_mar_in,
  output logic                 o_mdr_in,
  output logic                 o_mdr_out,
  output logic                 o_md_mux_read,
  output logic                 o_ir_in,
  output logic                 o_y_in,
  output logic                 o_z_low_in,
  output logic                 o_z_high_in,
  output logic                 o_z_low_out,
  output logic                 o_z_high_out,
  output logic                 o_hi_in,
  output logic                 o_lo_in,
  output logic [AluW-1:0]      o_alu_op,
  output logic                 o_halted,
  output logic                 o_illegal
);

  state_e          r_state;
  logic            r_illegal;

  opcode_t         w_opcode;
  op_class_e       w_class;
  logic [AluW-1:0] w_alu;
  logic [RegW-1:0] w_ra;
  logic [RegW-1:0] w_rb;
  logic [RegW-1:0] w_rc;
  state_e          w_boundary;
  logic            w_rin_en;
  logic            w_rout_en;
  logic [RegW-1:0] w_rin_idx;
  logic [RegW-1:0] w_rout_idx;
  logic            w_unused_ir;

  assign w_opcode    = i_ir[IrOpLsb +: OpW];
  assign w_ra        = i_ir[IrRaLsb +: RegW];
  assign w_rb        = i_ir[IrRbLsb +: RegW];
  assign w_rc        = i_ir[IrRcLsb +: RegW];
  assign w_class     = op_class(w_opcode);
  assign w_alu       = alu_onehot(w_opcode);
  assign w_unused_ir = ^i_ir[IrRcLsb-1:0];

  // Instruction boundary: keep going while run is high, otherwise park in IDLE
  assign w_boundary = i_run ? StT0 : StIdle;

  // State register and sticky illegal flag
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state   <= StIdle;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: if (i_run) r_state <= StT0;
        StT0:   r_state <= StT1;
        StT1:   r_state <= StT2;
        StT2:   r_state <= StT3;
        StT3: begin
          unique case (w_class)
            ClsHalt:    r_state <= StHalt;
            ClsIllegal: begin
              r_state   <= StHalt;
              r_illegal <= 1'b1;
            end
            default:    r_state <= StT4;
          endcase
        end
        StT4:   r_state <= (w_class == ClsUnary) ? w_boundary : StT5;
        StT5:   r_state <= (w_class == ClsMulDiv) ? StT6 : w_boundary;
        StT6:   r_state <= w_boundary;
        StHalt: r_state <= StHalt;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Datapath strobes decoded from state and the IR fields
  always_comb begin
    o_pc_in       = 1'b0;
    o_pc_out      = 1'b0;
    o_inc_pc      = 1'b0;
    o_mar_in      = 1'b0;
    o_mdr_in      = 1'b0;
    o_mdr_out     = 1'b0;
    o_md_mux_read = 1'b0;
    o_ir_in       = 1'b0;
    o_y_in        = 1'b0;
    o_z_low_in    = 1'b0;
    o_z_high_in   = 1'b0;
    o_z_low_out   = 1'b0;
    o_z_high_out  = 1'b0;
    o_hi_in       = 1'b0;
    o_lo_in       = 1'b0;
    o_alu_op      = '0;
    o_halted      = 1'b0;
    o_illegal     = r_illegal;
    w_rin_en      = 1'b0;
    w_rout_en     = 1'b0;
    w_rin_idx     = w_ra;
    w_rout_idx    = w_rb;

    unique case (r_state)
      StT0: begin
        o_pc_out   = 1'b1;
        o_mar_in   = 1'b1;
        o_inc_pc   = 1'b1;
        o_z_low_in = 1'b1;
      end
      StT1: begin
        o_z_low_out   = 1'b1;
        o_pc_in       = 1'b1;
        o_md_mux_read = 1'b1;
        o_mdr_in      = 1'b1;
      end
      StT2: begin
        o_mdr_out = 1'b1;
        o_ir_in   = 1'b1;
      end
      StT3: begin
        unique case (w_class)
          ClsTwoOp: begin
            w_rout_en = 1'b1;
            o_y_in    = 1'b1;
          end
          ClsMulDiv: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_ra;
            o_y_in     = 1'b1;
          end
          ClsUnary: begin
            w_rout_en  = 1'b1;
            o_alu_op   = w_alu;
            o_z_low_in = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        unique case (w_class)
          ClsTwoOp: begin
            w_rout_en  = 1'b1;
            w_rout_idx = w_rc;
            o_alu_op   = w_alu;
            o_z_low_in = 1'b1;
          end
          ClsMulDiv: begin
            w_rout_en   = 1'b1;
            o_alu_op    = w_alu;
            o_z_low_in  = 1'b1;
            o_z_high_in = 1'b1;
          end
          ClsUnary: begin
            o_z_low_out = 1'b1;
            w_rin_en    = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        if (w_class == ClsTwoOp) begin
          o_z_low_out = 1'b1;
          w_rin_en    = 1'b1;
        end else if (w_class == ClsMulDiv) begin
          o_z_low_out = 1'b1;
          o_lo_in     = 1'b1;
        end
      end
      StT6: begin
        if (w_class == ClsMulDiv) begin
          o_z_high_out = 1'b1;
          o_hi_in      = 1'b1;
        end
      end
      StHalt:  o_halted = 1'b1;
      default: ;
    endcase
  end

  reg_field_decode #(
    .IdxW (RegW)
  ) u_r_in_dec (
    .i_en     (w_rin_en),
    .i_idx    (w_rin_idx),
    .o_onehot (o_r_in)
  );

  reg_field_decode #(
    .IdxW (RegW)
  ) u_r_out_dec (
    .i_en     (w_rout_en),
    .i_idx    (w_rout_idx),
    .o_onehot (o_r_out)
  );

endmodule
